input_port_regs: RTL and testbench

INPUT_PORT_REGS -- requirements
Module: input_port_regs

---
 rtl/input_port_regs_pkg.sv | 12 +
 rtl/input_port_regs_if.sv | 19 +
 rtl/input_port_regs_button_debounce.sv | 36 +++
 rtl/input_port_regs.sv | 70 +++++++
 tb/tb_input_port_regs.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_port_regs_pkg.sv
// input_port_regs_pkg: shared io register constants for the button input port
// Provides the CPU data/index widths and the register offsets within the window.
package input_port_regs_pkg;
    localparam int REG_DATA_W  = 16;
    localparam int REG_INDEX_W = 12;
    typedef enum logic [1:0] {
        REG_STATE   = 2'd0,
        REG_PRESS   = 2'd1,
        REG_RELEASE = 2'd2,
        REG_MASK    = 2'd3
    } reg_off_e;
endpackage

// File: rtl/input_port_regs_if.sv
// input_port_regs_if: CPU register bus between a master (CPU) and the input port
// Signals: register_index (12), register_read / register_write strobes,
// register_write_value (16) from the master; register_read_value (16) from the slave.
interface input_port_regs_if;
    import input_port_regs_pkg::*;
    logic [REG_INDEX_W-1:0] register_index;
    logic                   register_read;
    logic                   register_write;
    logic [REG_DATA_W-1:0]  register_write_value;
    logic [REG_DATA_W-1:0]  register_read_value;
    modport master(
        output register_index, register_read, register_write, register_write_value,
        input  register_read_value
    );
    modport slave(
        input  register_index, register_read, register_write, register_write_value,
        output register_read_value
    );
endinterface

// File: rtl/input_port_regs_button_debounce.sv
// button_debounce: synchronizer chain plus stability counter for one button
// Ports: clk, reset_n (async, active-low), button (raw async level),
// level (debounced level), rise / fall (one-cycle pulses coincident with a level toggle).
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   flip;
    assign synced = sync[SYNC_STAGES-1];
    // The last counted cycle of disagreement toggles the level instead of counting further.
    assign flip = (synced != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && !level;
    assign fall = flip && level;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], button};
            cnt   <= (synced == level || flip) ? '0 : cnt + 1'b1;
            level <= level ^ flip;
        end
    end
endmodule

// File: rtl/input_port_regs.sv
// input_port_regs: debounced button inputs exposed as CPU registers with press interrupt
// Ports: clk, reset_n (async, active-low), buttons (raw levels, 1 = pressed),
// bus (slave side of the CPU register bus), irq_o (level irq = |(PRESS & MASK), registered).
// Window at BASE_INDEX: +0 STATE, +1 PRESS (clear-on-read), +2 RELEASE (clear-on-read), +3 MASK.
module input_port_regs
    import input_port_regs_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BASE_INDEX      = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input_port_regs_if.slave       bus,
    output logic                   irq_o
);
    localparam logic [REG_DATA_W-1:0] MASK_BITS = REG_DATA_W'((1 << NUM_BUTTONS) - 1);
    logic [NUM_BUTTONS-1:0] state;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] fall;
    logic [NUM_BUTTONS-1:0] press;
    logic [NUM_BUTTONS-1:0] rel;
    logic [REG_DATA_W-1:0]  mask;
    logic [REG_INDEX_W-1:0] off;
    logic                   in_win;
    logic                   rd_hit;
    logic                   wr_hit;
    reg_off_e               sel;
    // Unsigned offset from the base: anything below the base wraps to a large value.
    assign off    = bus.register_index - REG_INDEX_W'(BASE_INDEX);
    assign in_win = off < REG_INDEX_W'(4);
    assign sel    = reg_off_e'(off[1:0]);
    assign rd_hit = bus.register_read && in_win;
    assign wr_hit = bus.register_write && in_win && sel == REG_MASK;
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .button (buttons[i]),
            .level  (state[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.register_read_value <= '0;
            press                   <= '0;
            rel                     <= '0;
            mask                    <= '0;
            irq_o                   <= 1'b0;
        end else begin
            if (rd_hit)
                bus.register_read_value <= sel == REG_STATE   ? REG_DATA_W'(state) :
                                           sel == REG_PRESS   ? REG_DATA_W'(press) :
                                           sel == REG_RELEASE ? REG_DATA_W'(rel)   : mask;
            // A new event is OR-ed in after the clear so it survives a coincident read.
            press <= (rd_hit && sel == REG_PRESS ? '0 : press) | rise;
            rel   <= (rd_hit && sel == REG_RELEASE ? '0 : rel) | fall;
            if (wr_hit)
                mask <= bus.register_write_value & MASK_BITS;
            irq_o <= |(press & mask[NUM_BUTTONS-1:0]);
        end
    end
endmodule

// File: tb/tb_input_port_regs.sv
// tb_input_port_regs: directed scenarios plus randomized traffic against a behavioural model
module tb_input_port_regs;
    localparam int N    = 4;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int BASE = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] buttons;
    logic         irq_o;
    int           errors = 0;
    int           checks = 0;

    input_port_regs_if bus();

    input_port_regs #(
        .NUM_BUTTONS    (N),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .BASE_INDEX     (BASE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .buttons(buttons),
        .bus    (bus),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: each channel sees its raw input S edges late and changes its
    // debounced level once that delayed input has disagreed for D consecutive edges.
    logic [N-1:0]  m_q[$];
    logic [N-1:0]  m_db, m_press, m_rel, m_used, m_rise, m_fall;
    logic [15:0]   m_mask, m_rd;
    logic          m_irq;
    int            m_run[N];
    int            m_off;
    bit            m_win;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q = {};
            for (int k = 0; k < S; k++) m_q.push_back('0);
            m_db = '0; m_press = '0; m_rel = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
            for (int k = 0; k < N; k++) m_run[k] = 0;
        end else begin
            m_off = int'(bus.register_index) - BASE;
            m_win = m_off >= 0 && m_off <= 3;
            if (bus.register_read && m_win)
                m_rd = m_off == 0 ? 16'(m_db) : m_off == 1 ? 16'(m_press) :
                       m_off == 2 ? 16'(m_rel) : m_mask;
            m_irq  = |(m_press & m_mask[N-1:0]);
            m_used = m_q.pop_front();
            m_q.push_back(buttons);
            m_rise = '0;
            m_fall = '0;
            for (int k = 0; k < N; k++) begin
                m_run[k] = (m_used[k] != m_db[k]) ? m_run[k] + 1 : 0;
                if (m_run[k] == D) begin
                    m_run[k] = 0;
                    m_db[k]  = ~m_db[k];
                    if (m_db[k]) m_rise[k] = 1'b1;
                    else         m_fall[k] = 1'b1;
                end
            end
            if (bus.register_read && m_win && m_off == 1) m_press = '0;
            if (bus.register_read && m_win && m_off == 2) m_rel = '0;
            m_press = m_press | m_rise;
            m_rel   = m_rel | m_fall;
            if (bus.register_write && m_win && m_off == 3)
                m_mask = {12'b0, bus.register_write_value[N-1:0]};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input int idx, output logic [15:0] v);
        bus.register_index = 12'(idx);
        bus.register_read  = 1'b1;
        @(negedge clk);
        bus.register_read = 1'b0;
        v = bus.register_read_value;
    endtask

    task automatic wr(input int idx, input logic [15:0] d);
        bus.register_index       = 12'(idx);
        bus.register_write       = 1'b1;
        bus.register_write_value = d;
        @(negedge clk);
        bus.register_write = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        reset_n = 1'b0;
        buttons = '0;
        bus.register_index = '0;
        bus.register_read = 1'b0;
        bus.register_write = 1'b0;
        bus.register_write_value = '0;
        tick(3);
        checks++;
        if (bus.register_read_value !== 16'h0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdata=%h irq=%b want 0000/0", bus.register_read_value, irq_o);
        end
        reset_n = 1'b1;
        rd(BASE, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL reset_state: got %h want 0000", v); end
        rd(BASE + 3, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL reset_mask: got %h want 0000", v); end
    endtask

    task automatic test_press;
        logic [15:0] v;
        buttons[0] = 1'b1;
        tick(4);
        rd(BASE, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL state_early: got %h want 0000", v); end
        tick(1);
        rd(BASE, v);
        checks++;
        if (v !== 16'h1) begin errors++; $display("FAIL state_late: got %h want 0001", v); end
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h1) begin errors++; $display("FAIL press_bit0: got %h want 0001", v); end
        rd(BASE + 2, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL release_none: got %h want 0000", v); end
        buttons[0] = 1'b0;
        tick(8);
        rd(BASE + 2, v);
        checks++;
        if (v !== 16'h1) begin errors++; $display("FAIL release_bit0: got %h want 0001", v); end
        rd(BASE, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL state_released: got %h want 0000", v); end
    endtask

    task automatic test_glitch;
        logic [15:0] v;
        buttons[1] = 1'b1;
        tick(3);
        buttons[1] = 1'b0;
        tick(10);
        for (int r = 0; r < 3; r++) begin
            rd(BASE + r, v);
            checks++;
            if (v !== 16'h0) begin errors++; $display("FAIL glitch_reg%0d: got %h want 0000", r, v); end
        end
    endtask

    task automatic test_clear_on_read;
        logic [15:0] v;
        buttons[2] = 1'b1;
        tick(8);
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h4) begin errors++; $display("FAIL press_first: got %h want 0004", v); end
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL press_second: got %h want 0000", v); end
        buttons[2] = 1'b0;
        tick(8);
        rd(BASE + 2, v);
        checks++;
        if (v !== 16'h4) begin errors++; $display("FAIL release_first: got %h want 0004", v); end
        rd(BASE + 2, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL release_second: got %h want 0000", v); end
    endtask

    task automatic test_coincident;
        logic [15:0] v;
        buttons[0] = 1'b1;
        tick(5);
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL coincident_read: got %h want 0000", v); end
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h1) begin errors++; $display("FAIL coincident_kept: got %h want 0001", v); end
        buttons[0] = 1'b0;
        tick(8);
        rd(BASE + 2, v);
    endtask

    task automatic test_mask_irq;
        logic [15:0] v;
        wr(BASE + 3, 16'hFFF2);
        rd(BASE + 3, v);
        checks++;
        if (v !== 16'h2) begin errors++; $display("FAIL mask_write: got %h want 0002", v); end
        wr(BASE, 16'hFFFF);
        wr(BASE + 2, 16'hFFFF);
        wr(BASE - 1, 16'hFFFF);
        wr(BASE + 4, 16'hFFFF);
        rd(BASE + 3, v);
        checks++;
        if (v !== 16'h2) begin errors++; $display("FAIL mask_ignored_writes: got %h want 0002", v); end
        bus.register_index       = 12'(BASE + 3);
        bus.register_read        = 1'b1;
        bus.register_write       = 1'b1;
        bus.register_write_value = 16'h0005;
        @(negedge clk);
        bus.register_read  = 1'b0;
        bus.register_write = 1'b0;
        checks++;
        if (bus.register_read_value !== 16'h2) begin
            errors++; $display("FAIL rw_same_cycle: got %h want 0002", bus.register_read_value);
        end
        rd(BASE + 3, v);
        checks++;
        if (v !== 16'h5) begin errors++; $display("FAIL rw_mask_after: got %h want 0005", v); end
        wr(BASE + 3, 16'h0002);
        buttons[1] = 1'b1;
        tick(6);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_before: got %b want 0", irq_o); end
        tick(1);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq_o); end
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h2 || irq_o !== 1'b1) begin
            errors++; $display("FAIL irq_read_press: got %h/%b want 0002/1", v, irq_o);
        end
        tick(1);
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", irq_o); end
        buttons[1] = 1'b0;
        tick(8);
        rd(BASE + 2, v);
        buttons[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            checks++;
            if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_masked c%0d: got %b want 0", c, irq_o); end
        end
    endtask

    task automatic test_window_reset;
        logic [15:0] v;
        wr(BASE + 3, 16'h0001);
        tick(2);
        checks++;
        if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_pending: got %b want 1", irq_o); end
        rd(BASE + 3, v);
        rd(2, v);
        checks++;
        if (v !== 16'h1) begin errors++; $display("FAIL out_of_window: got %h want 0001", v); end
        buttons[3] = 1'b1;
        tick(3);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.register_read_value !== 16'h0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got rdata=%h irq=%b want 0000/0", bus.register_read_value, irq_o);
        end
        tick(2);
        reset_n = 1'b1;
        tick(5);
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL post_reset_early: got %h want 0000", v); end
        rd(BASE + 1, v);
        checks++;
        if (v !== 16'h9) begin errors++; $display("FAIL post_reset_press: got %h want 0009", v); end
        checks++;
        if (irq_o !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b want 0", irq_o); end
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 7) == 0) buttons[k] = ~buttons[k];
            bus.register_index       = 12'($urandom_range(BASE - 2, BASE + 5));
            bus.register_read        = $urandom_range(0, 2) == 0;
            bus.register_write       = $urandom_range(0, 3) == 0;
            bus.register_write_value = 16'($urandom);
            @(negedge clk);
            checks++;
            if (bus.register_read_value !== m_rd) begin
                errors++; $display("FAIL rand_rdata c%0d: got %h want %h", c, bus.register_read_value, m_rd);
            end
            checks++;
            if (irq_o !== m_irq) begin
                errors++; $display("FAIL rand_irq c%0d: got %b want %b", c, irq_o, m_irq);
            end
        end
        bus.register_read  = 1'b0;
        bus.register_write = 1'b0;
    endtask

    initial begin
        test_reset;
        test_press;
        test_glitch;
        test_clear_on_read;
        test_coincident;
        test_mask_irq;
        test_window_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
